// File: rtl/uart_lite_slave.sv
// uart_lite_slave: AXI4-lite responder with the UART-Lite register map
// (RX_FIFO 0x0, TX_FIFO 0x4, STAT_REG 0x8, CTRL_REG 0xC) backed by RX/TX byte FIFOs.
module uart_lite_slave #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [3:0]  s_axi_araddr,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   input  logic [3:0]  s_axi_awaddr,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        intr
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   localparam logic [1:0] A_RX   = 2'd0;
   localparam logic [1:0] A_TX   = 2'd1;
   localparam logic [1:0] A_STAT = 2'd2;
   localparam logic [1:0] A_CTRL = 2'd3;

   logic          r_arready, r_rvalid, r_awready, r_bvalid;
   logic          r_intr, r_intr_en, r_overrun, r_rx_ne_d, r_tx_ne_d;
   logic [7:0]    r_rdata;
   logic [7:0]    r_rx_mem [FIFO_DEPTH];
   logic [7:0]    r_tx_mem [FIFO_DEPTH];
   logic [AW-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
   logic [CW-1:0] r_rx_cnt, r_tx_cnt;

   logic          w_rd_hs, w_wr_hs;
   logic [1:0]    w_rd_addr, w_wr_addr;
   logic          w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
   logic          w_rx_push, w_rx_pop, w_rx_clr, w_rx_ovf;
   logic          w_tx_push, w_tx_pop, w_tx_clr;
   logic          w_stat_rd;
   logic [7:0]    w_stat, w_rd_mux;
   logic          w_unused;

   assign w_rd_addr  = s_axi_araddr[3:2];
   assign w_wr_addr  = s_axi_awaddr[3:2];
   assign w_rd_hs    = s_axi_arvalid & r_arready;
   assign w_wr_hs    = s_axi_awvalid & s_axi_wvalid & r_awready;

   // flags are taken from the registered counts, i.e. start-of-cycle state
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == FULL_CNT);
   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_tx_full  = (r_tx_cnt == FULL_CNT);

   assign w_rx_push  = rx_valid & ~w_rx_full;
   assign w_rx_ovf   = rx_valid & w_rx_full;
   assign w_rx_pop   = w_rd_hs & (w_rd_addr == A_RX) & ~w_rx_empty;
   assign w_rx_clr   = w_wr_hs & (w_wr_addr == A_CTRL) & s_axi_wdata[1];

   assign w_tx_push  = w_wr_hs & (w_wr_addr == A_TX) & ~w_tx_full;
   assign w_tx_pop   = ~w_tx_empty & tx_ready;
   assign w_tx_clr   = w_wr_hs & (w_wr_addr == A_CTRL) & s_axi_wdata[0];

   assign w_stat_rd  = w_rd_hs & (w_rd_addr == A_STAT);
   assign w_stat     = {2'b00, r_overrun, r_intr_en, w_tx_full, w_tx_empty, w_rx_full, ~w_rx_empty};

   assign w_unused   = ^{s_axi_wstrb, s_axi_araddr[1:0], s_axi_awaddr[1:0], s_axi_wdata[31:8]};

   // read data selected at the AR handshake
   always_comb begin
      w_rd_mux = 8'h00;
      case (w_rd_addr)
         A_RX:    if (!w_rx_empty) w_rd_mux = r_rx_mem[r_rx_rp];
         A_STAT:  w_rd_mux = w_stat;
         default: w_rd_mux = 8'h00;
      endcase
   end

   // AXI handshakes, control/status bits and interrupt edge detect
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= 8'h00;
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
         r_intr_en <= 1'b0;
         r_overrun <= 1'b0;
         r_rx_ne_d <= 1'b0;
         r_tx_ne_d <= 1'b0;
         r_intr    <= 1'b0;
      end else begin
         r_arready <= s_axi_arvalid & ~r_rvalid & ~r_arready;
         if (w_rd_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_mux;
         end else if (s_axi_rready) begin
            r_rvalid <= 1'b0;
         end
         // AW and W are only ever accepted together
         r_awready <= s_axi_awvalid & s_axi_wvalid & ~r_bvalid & ~r_awready;
         if (w_wr_hs)
            r_bvalid <= 1'b1;
         else if (s_axi_bready)
            r_bvalid <= 1'b0;
         if (w_wr_hs && (w_wr_addr == A_CTRL))
            r_intr_en <= s_axi_wdata[4];
         // a new overrun beats the clear-on-read of the same cycle
         if (w_rx_ovf)
            r_overrun <= 1'b1;
         else if (w_stat_rd)
            r_overrun <= 1'b0;
         r_rx_ne_d <= ~w_rx_empty;
         r_tx_ne_d <= ~w_tx_empty;
         r_intr    <= r_intr_en & ((~w_rx_empty & ~r_rx_ne_d) | (w_tx_empty & r_tx_ne_d));
      end
   end

   // RX FIFO pointers and occupancy; clear overrides push/pop
   always_ff @(posedge clk) begin
      if (!rstn || w_rx_clr) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
         r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
      end
   end

   // TX FIFO pointers and occupancy; clear overrides push/pop
   always_ff @(posedge clk) begin
      if (!rstn || w_tx_clr) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
         r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
      end
   end

   // FIFO storage, no reset needed since occupancy gates every read
   always_ff @(posedge clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wp] <= rx_byte;
      if (w_tx_push) r_tx_mem[r_tx_wp] <= s_axi_wdata[7:0];
   end

   assign s_axi_arready = r_arready;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rdata   = {24'h000000, r_rdata};
   assign s_axi_rresp   = 2'b00;
   assign s_axi_awready = r_awready;
   assign s_axi_wready  = r_awready;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = 2'b00;
   assign rx_ready      = 1'b1;
   assign tx_byte       = r_tx_mem[r_tx_rp];
   assign tx_valid      = ~w_tx_empty;
   assign intr          = r_intr;

endmodule
